// File: rtl/subleq_core_param.sv
// Parametrised SUBLEQ core: mem[A] -= mem[B], branch to C when the result is <= 0.
// Stream I/O and halt live at the top three addresses; debug start/step/breakpoint.
module subleq_core_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic              set_pc,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [1:0]        halt_cause
);

  localparam int MEM_N = (1 << ADDR_W) - 3;
  localparam logic [ADDR_W-1:0] TOP      = '1;
  localparam logic [ADDR_W-1:0] IN_ADDR  = TOP - ADDR_W'(2);
  localparam logic [ADDR_W-1:0] OUT_ADDR = TOP - ADDR_W'(1);
  localparam logic [ADDR_W-1:0] MAX_PC   = TOP - ADDR_W'(5);

  typedef enum logic [2:0] {
    S_HALT, S_FA, S_FB, S_FC, S_RA, S_RB, S_WB
  } state_t;

  state_t state, state_d;
  logic [DATA_W-1:0] mem [MEM_N];
  logic [ADDR_W-1:0] pc_d, a, b, c;
  logic [ADDR_W-1:0] rd_addr, next_pc, start_pc;
  logic [DATA_W-1:0] va, vb, rd_word, rd_val, r;
  logic [1:0] cause_d;
  logic step_mode, step_mode_d;
  logic first, first_d;
  logic run_q, run_rise, leq;

  always_comb begin
    rd_addr = pc;
    unique case (state)
      S_FB:    rd_addr = pc + ADDR_W'(1);
      S_FC:    rd_addr = pc + ADDR_W'(2);
      S_RA:    rd_addr = a;
      S_RB:    rd_addr = b;
      default: rd_addr = pc;
    endcase
  end

  assign rd_word  = (rd_addr < IN_ADDR) ? mem[rd_addr] : '0;
  assign rd_val   = (rd_addr == IN_ADDR) ? in_data : rd_word;
  assign dbg_data = (dbg_addr < IN_ADDR) ? mem[dbg_addr] : '0;

  assign r        = va - vb;
  assign leq      = r[DATA_W-1] | (r == '0);
  assign next_pc  = leq ? c : pc + ADDR_W'(3);
  assign run_rise = run & ~run_q;
  assign start_pc = set_pc ? pc_in : pc;

  assign halted    = (state == S_HALT);
  assign out_valid = (state == S_WB) && (a == OUT_ADDR);
  assign out_data  = out_valid ? r : '0;
  assign in_ready  = in_valid &&
                     (((state == S_RA) && (a == IN_ADDR)) ||
                      ((state == S_RB) && (b == IN_ADDR)));

  always_comb begin
    state_d     = state;
    pc_d        = pc;
    cause_d     = halt_cause;
    step_mode_d = step_mode;
    first_d     = first;
    unique case (state)
      S_HALT: begin
        if (set_pc) pc_d = pc_in;
        if (run_rise || step) begin
          if (start_pc > MAX_PC) begin
            cause_d = 2'd1;
          end else begin
            state_d     = S_FA;
            step_mode_d = ~run_rise;
            first_d     = 1'b1;
          end
        end
      end
      S_FA: state_d = S_FB;
      S_FB: state_d = S_FC;
      S_FC: state_d = S_RA;
      S_RA: if (a != IN_ADDR || in_valid) state_d = S_RB;
      S_RB: if (b != IN_ADDR || in_valid) state_d = S_WB;
      S_WB: begin
        if (a != OUT_ADDR || out_ready) begin
          pc_d    = next_pc;
          first_d = 1'b0;
          // the first instruction after a start never breaks, so resume works
          if (next_pc > MAX_PC) begin
            state_d = S_HALT;
            cause_d = 2'd1;
          end else if (!run || step_mode) begin
            state_d = S_HALT;
            cause_d = 2'd2;
          end else if (bp_en && next_pc == bp_addr && !first) begin
            state_d = S_HALT;
            cause_d = 2'd3;
          end else begin
            state_d = S_FA;
          end
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_HALT;
      pc         <= '0;
      halt_cause <= 2'd0;
      step_mode  <= 1'b0;
      first      <= 1'b0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      halt_cause <= cause_d;
      step_mode  <= step_mode_d;
      first      <= first_d;
    end
  end

  always_ff @(posedge clk) begin
    run_q <= run;
    unique case (state)
      S_FA:    a  <= rd_val[ADDR_W-1:0];
      S_FB:    b  <= rd_val[ADDR_W-1:0];
      S_FC:    c  <= rd_val[ADDR_W-1:0];
      S_RA:    va <= rd_val;
      S_RB:    vb <= rd_val;
      default: ;
    endcase
    if (rst_n && state == S_WB && a < IN_ADDR)
      mem[a] <= r;
    if (rst_n && state == S_HALT && ld_en && ld_addr < IN_ADDR)
      mem[ld_addr] <= ld_data;
  end

endmodule

// File: tb/tb_subleq_core_param.sv
// Directed bench for subleq_core_param: 8/8 core plus a 12/6 instance.
module tb_subleq_core_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, run, step, set_pc, ld_en, bp_en, in_valid, in_ready;
  logic       out_valid, out_ready, halted;
  logic [7:0] pc_in, ld_addr, ld_data, bp_addr, in_data, out_data;
  logic [7:0] dbg_addr, dbg_data, pc;
  logic [1:0] halt_cause;

  logic        q_run, q_step, q_set_pc, q_ld_en, q_bp_en, q_in_valid, q_in_ready;
  logic        q_out_valid, q_out_ready, q_halted;
  logic [5:0]  q_pc_in, q_ld_addr, q_bp_addr, q_dbg_addr, q_pc;
  logic [11:0] q_ld_data, q_in_data, q_out_data, q_dbg_data;
  logic [1:0]  q_cause;

  subleq_core_param #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step),
    .set_pc(set_pc), .pc_in(pc_in),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .bp_en(bp_en), .bp_addr(bp_addr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .pc(pc), .halted(halted), .halt_cause(halt_cause)
  );

  subleq_core_param #(.DATA_W(12), .ADDR_W(6)) dut_q (
    .clk(clk), .rst_n(rst_n), .run(q_run), .step(q_step),
    .set_pc(q_set_pc), .pc_in(q_pc_in),
    .ld_en(q_ld_en), .ld_addr(q_ld_addr), .ld_data(q_ld_data),
    .bp_en(q_bp_en), .bp_addr(q_bp_addr),
    .in_data(q_in_data), .in_valid(q_in_valid), .in_ready(q_in_ready),
    .out_data(q_out_data), .out_valid(q_out_valid), .out_ready(q_out_ready),
    .dbg_addr(q_dbg_addr), .dbg_data(q_dbg_data),
    .pc(q_pc), .halted(q_halted), .halt_cause(q_cause)
  );

  typedef struct {
    logic [7:0] a, b, c, va, vb, exp_m, exp_pc;
    logic [1:0] exp_cause;
  } vec_t;

  vec_t tbl[8];
  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] ad, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = ad; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic q_load(input logic [5:0] ad, input logic [11:0] d);
    q_ld_en = 1'b1; q_ld_addr = ad; q_ld_data = d;
    @(negedge clk);
    q_ld_en = 1'b0;
  endtask

  task automatic peek(input logic [7:0] ad, output int d);
    dbg_addr = ad;
    #1;
    d = int'(dbg_data);
  endtask

  task automatic q_peek(input logic [5:0] ad, output int d);
    q_dbg_addr = ad;
    #1;
    d = int'(q_dbg_data);
  endtask

  task automatic step_from(input logic [7:0] p);
    set_pc = 1'b1; pc_in = p; step = 1'b1;
  endtask

  task automatic run_from(input logic [7:0] p);
    set_pc = 1'b1; pc_in = p; run = 1'b1;
  endtask

  // cycles from the start request until halted is seen
  task automatic wait_halt(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      step = 1'b0; set_pc = 1'b0;
      n++;
    end while (!halted && n < budget);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, d, cnt, bad;
    tbl[0] = '{8'd30, 8'd31, 8'd40, 8'd10,  8'd3,   8'd7,   8'd3,   2'd2};
    tbl[1] = '{8'd30, 8'd31, 8'd40, 8'd3,   8'd3,   8'd0,   8'd40,  2'd2};
    tbl[2] = '{8'd30, 8'd31, 8'd40, 8'd3,   8'd10,  8'd249, 8'd40,  2'd2};
    tbl[3] = '{8'd30, 8'd31, 8'd40, 8'd128, 8'd1,   8'd127, 8'd3,   2'd2};
    tbl[4] = '{8'd30, 8'd31, 8'd40, 8'd127, 8'd255, 8'd128, 8'd40,  2'd2};
    tbl[5] = '{8'd32, 8'd32, 8'd12, 8'd5,   8'd5,   8'd0,   8'd12,  2'd2};
    tbl[6] = '{8'd30, 8'd31, 8'd251, 8'd1,  8'd2,   8'd255, 8'd251, 2'd1};
    tbl[7] = '{8'd30, 8'd31, 8'd250, 8'd0,  8'd0,   8'd0,   8'd250, 2'd2};

    rst_n = 1'b0; run = 1'b0; step = 1'b0; set_pc = 1'b0; pc_in = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; bp_en = 1'b0; bp_addr = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1; dbg_addr = '0;
    q_run = 1'b0; q_step = 1'b0; q_set_pc = 1'b0; q_pc_in = '0;
    q_ld_en = 1'b0; q_ld_addr = '0; q_ld_data = '0; q_bp_en = 1'b0;
    q_bp_addr = '0; q_in_data = '0; q_in_valid = 1'b0; q_out_ready = 1'b1;
    q_dbg_addr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_halted", int'(halted), 1);
    chk("rst_cause", int'(halt_cause), 0);
    chk("rst_pc", int'(pc), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);

    // basic two-instruction program
    load(0, 6); load(1, 7); load(2, 3);
    load(3, 8); load(4, 8); load(5, 255);
    load(6, 5); load(7, 3); load(8, 9);
    run_from(0);
    @(negedge clk); set_pc = 1'b0;
    repeat (6) @(negedge clk);
    chk("basic_pc_after_i0", int'(pc), 3);
    peek(6, d); chk("basic_mem6", d, 2);
    repeat (5) @(negedge clk);
    chk("basic_running_c12", int'(halted), 0);
    @(negedge clk);
    chk("basic_halted_c13", int'(halted), 1);
    chk("basic_cause", int'(halt_cause), 1);
    chk("basic_pc", int'(pc), 255);
    peek(8, d); chk("basic_mem8", d, 0);
    run = 1'b0; @(negedge clk);
    run = 1'b1; repeat (3) @(negedge clk);
    chk("badpc_stay_halted", int'(halted), 1);
    chk("badpc_cause", int'(halt_cause), 1);
    run = 1'b0;
    peek(253, d); chk("dbg_in_addr_zero", d, 0);

    // single-instruction vectors
    for (int i = 0; i < 8; i++) begin
      load(0, tbl[i].a); load(1, tbl[i].b); load(2, tbl[i].c);
      load(tbl[i].a, tbl[i].va); load(tbl[i].b, tbl[i].vb);
      step_from(0);
      wait_halt(40, n);
      chk($sformatf("vec%0d_cycles", i), n, 7);
      peek(tbl[i].a, d);
      chk($sformatf("vec%0d_mem", i), d, int'(tbl[i].exp_m));
      chk($sformatf("vec%0d_pc", i), int'(pc), int'(tbl[i].exp_pc));
      chk($sformatf("vec%0d_cause", i), int'(halt_cause), int'(tbl[i].exp_cause));
    end

    // input stall
    load(0, 10); load(1, 253); load(2, 3); load(10, 9);
    step_from(0);
    cnt = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      step = 1'b0; set_pc = 1'b0;
      in_valid = (i == 9); in_data = 5;
      #1;
      if (in_ready) cnt++;
    end
    in_valid = 1'b0;
    chk("in_ready_cycles", cnt, 1);
    peek(10, d); chk("in_mem10", d, 4);
    chk("in_pc", int'(pc), 3);
    chk("in_halted", int'(halted), 1);

    // output stall
    load(0, 254); load(1, 11); load(2, 3); load(11, 2);
    step_from(0);
    cnt = 0; bad = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      step = 1'b0; set_pc = 1'b0;
      out_ready = (i >= 9);
      #1;
      if (out_valid) begin
        cnt++;
        if (out_data != 8'hFE) bad++;
      end
    end
    out_ready = 1'b1;
    chk("out_valid_cycles", cnt, 4);
    chk("out_data_bad_cycles", bad, 0);
    chk("out_valid_cleared", int'(out_valid), 0);
    peek(11, d); chk("out_mem11", d, 2);
    chk("out_pc", int'(pc), 3);

    // step and breakpoint on a four-instruction loop
    for (int i = 0; i < 3; i++) begin
      load(8'(3 * i), 255); load(8'(3 * i + 1), 20); load(8'(3 * i + 2), 0);
    end
    load(9, 255); load(10, 21); load(11, 0);
    load(20, 255); load(21, 0);
    step_from(0);
    wait_halt(40, n);
    chk("step_cycles", n, 7);
    chk("step_cause", int'(halt_cause), 2);
    chk("step_pc", int'(pc), 3);
    bp_en = 1'b1; bp_addr = 6;
    run_from(0);
    wait_halt(80, n);
    chk("bp_cycles", n, 13);
    chk("bp_cause", int'(halt_cause), 3);
    chk("bp_pc", int'(pc), 6);
    run = 1'b0; @(negedge clk);
    run = 1'b1;
    wait_halt(80, n);
    chk("resume_cycles", n, 25);
    chk("resume_cause", int'(halt_cause), 3);
    chk("resume_pc", int'(pc), 6);
    run = 1'b0; bp_en = 1'b0;
    @(negedge clk);

    // reset during S_RB
    load(3, 20); load(4, 21); load(5, 0); load(20, 7); load(21, 3);
    step_from(3);
    @(negedge clk); step = 1'b0; set_pc = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_running", int'(halted), 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    peek(20, d); chk("mid_mem20", d, 7);
    chk("mid_pc", int'(pc), 0);
    chk("mid_halted", int'(halted), 1);
    chk("mid_cause", int'(halt_cause), 0);
    chk("mid_in_ready", int'(in_ready), 0);
    chk("mid_out_valid", int'(out_valid), 0);

    // 12-bit data, 6-bit address instance
    q_load(0, 10); q_load(1, 11); q_load(2, 6);
    q_load(6, 12); q_load(7, 12); q_load(8, 59);
    q_load(10, 0); q_load(11, 1); q_load(12, 5);
    q_run = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 7) chk("q_pc_after_i0", int'(q_pc), 6);
    end while (!q_halted && n < 60);
    chk("q_cycles", n, 13);
    chk("q_pc", int'(q_pc), 59);
    chk("q_cause", int'(q_cause), 1);
    q_peek(10, d); chk("q_mem10_wrap", d, 12'hFFF);
    q_peek(12, d); chk("q_mem12", d, 0);
    q_peek(61, d); chk("q_dbg_in_zero", d, 0);
    q_run = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
